// File: rtl/refill_read_arbiter.sv
// Refill read arbiter: shares one memory line-read channel between the
// ICache and DCache refill paths, one transaction in flight at a time.
module refill_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_arvalid_i,
    input  logic [ADDR_W-1:0] ic_araddr_i,
    output logic              ic_arready_o,
    output logic              ic_rvalid_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    input  logic              ic_rready_i,
    input  logic              dc_arvalid_i,
    input  logic [ADDR_W-1:0] dc_araddr_i,
    output logic              dc_arready_o,
    output logic              dc_rvalid_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    input  logic              dc_rready_i,
    output logic              mem_arvalid_o,
    output logic [ADDR_W-1:0] mem_araddr_o,
    input  logic              mem_arready_i,
    input  logic              mem_rvalid_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              mem_rready_o,
    output logic              busy_o
);

    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_line;

    logic              w_ic_win;
    logic              w_dc_win;
    logic              w_grant;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_owner_rready;
    logic              w_resp;

    // Round-robin pick between the two requesters, only while idle
    always_comb begin
        w_ic_win = 1'b0;
        w_dc_win = 1'b0;
        if (r_state == S_IDLE && !rst) begin
            if (ic_arvalid_i && dc_arvalid_i) begin
                w_ic_win = (r_last == OWN_DC);
                w_dc_win = (r_last == OWN_IC);
            end else begin
                w_ic_win = ic_arvalid_i;
                w_dc_win = dc_arvalid_i;
            end
        end
        w_grant    = w_ic_win | w_dc_win;
        w_win_addr = (w_dc_win ? dc_araddr_i : ic_araddr_i) & LINE_MASK;
    end

    // Next-state decode of the transaction sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_rready = (r_owner == OWN_DC) ? dc_rready_i : ic_rready_i;
        unique case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_ADDR;
            S_ADDR: if (mem_arready_i) w_state_nxt = S_DATA;
            S_DATA: if (mem_rvalid_i) w_state_nxt = S_RESP;
            S_RESP: if (w_owner_rready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner, round-robin history, address and line buffer capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_IC;
            r_last  <= OWN_DC;
            r_addr  <= '0;
            r_line  <= '0;
        end else begin
            if (w_grant) begin
                r_addr  <= w_win_addr;
                r_owner <= w_dc_win;
                r_last  <= w_dc_win;
            end
            if (r_state == S_DATA && mem_rvalid_i) begin
                r_line <= mem_rdata_i;
            end
        end
    end

    assign w_resp = (r_state == S_RESP);

    assign ic_arready_o  = w_ic_win;
    assign dc_arready_o  = w_dc_win;
    assign mem_arvalid_o = (r_state == S_ADDR);
    assign mem_araddr_o  = r_addr;
    assign mem_rready_o  = (r_state == S_DATA);
    assign busy_o        = (r_state != S_IDLE);

    assign ic_rvalid_o = w_resp && (r_owner == OWN_IC);
    assign dc_rvalid_o = w_resp && (r_owner == OWN_DC);
    assign ic_rdata_o  = ic_rvalid_o ? r_line : '0;
    assign dc_rdata_o  = dc_rvalid_o ? r_line : '0;

endmodule

// File: tb/tb_refill_read_arbiter.sv
// Directed bench for refill_read_arbiter: single refill, round-robin,
// memory/owner back-pressure and mid-transaction reset.
module tb_refill_read_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_arvalid_i;
    logic [31:0]  ic_araddr_i;
    logic         ic_arready_o;
    logic         ic_rvalid_o;
    logic [255:0] ic_rdata_o;
    logic         ic_rready_i;
    logic         dc_arvalid_i;
    logic [31:0]  dc_araddr_i;
    logic         dc_arready_o;
    logic         dc_rvalid_o;
    logic [255:0] dc_rdata_o;
    logic         dc_rready_i;
    logic         mem_arvalid_o;
    logic [31:0]  mem_araddr_o;
    logic         mem_arready_i;
    logic         mem_rvalid_i;
    logic [255:0] mem_rdata_i;
    logic         mem_rready_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] D1 = 256'h12345678_9abcdef0_0fedcba9_87654321_deadbeef_cafef00d_a5a55a5a_78910234;
    localparam logic [255:0] D2 = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff;
    localparam logic [255:0] D5 = 256'h5555_0000_5555_0000_5555_0000_5555_0000_5555_0000_5555_0000_5555_0000_5555_0001;
    localparam logic [255:0] D6 = 256'h6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666_6666;

    refill_read_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_arvalid_i  (ic_arvalid_i),
        .ic_araddr_i   (ic_araddr_i),
        .ic_arready_o  (ic_arready_o),
        .ic_rvalid_o   (ic_rvalid_o),
        .ic_rdata_o    (ic_rdata_o),
        .ic_rready_i   (ic_rready_i),
        .dc_arvalid_i  (dc_arvalid_i),
        .dc_araddr_i   (dc_araddr_i),
        .dc_arready_o  (dc_arready_o),
        .dc_rvalid_o   (dc_rvalid_o),
        .dc_rdata_o    (dc_rdata_o),
        .dc_rready_i   (dc_rready_i),
        .mem_arvalid_o (mem_arvalid_o),
        .mem_araddr_o  (mem_araddr_o),
        .mem_arready_i (mem_arready_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rready_o  (mem_rready_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE with mem_arready_i=1 and zero memory wait
    task automatic run_txn(input string tag, input logic exp_dc,
                           input logic [31:0] exp_addr, input logic [255:0] data);
        #1;
        chk({tag, "_ic_arready"}, ic_arready_o, !exp_dc);
        chk({tag, "_dc_arready"}, dc_arready_o, exp_dc);
        tick;
        #1;
        chk({tag, "_mem_arvalid"}, mem_arvalid_o, 1'b1);
        chk({tag, "_mem_araddr"}, mem_araddr_o, exp_addr);
        chk({tag, "_busy_arready"}, {ic_arready_o, dc_arready_o}, 2'b00);
        tick;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        #1;
        chk({tag, "_mem_rready"}, mem_rready_o, 1'b1);
        tick;
        mem_rvalid_i = 1'b0;
        ic_rready_i  = 1'b1;
        dc_rready_i  = 1'b1;
        #1;
        chk({tag, "_ic_rvalid"}, ic_rvalid_o, !exp_dc);
        chk({tag, "_dc_rvalid"}, dc_rvalid_o, exp_dc);
        chk({tag, "_rdata"}, exp_dc ? dc_rdata_o : ic_rdata_o, data);
        tick;
        ic_rready_i = 1'b0;
        dc_rready_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ic_arvalid_i  = 1'b0;
        ic_araddr_i   = '0;
        ic_rready_i   = 1'b0;
        dc_arvalid_i  = 1'b0;
        dc_araddr_i   = '0;
        dc_rready_i   = 1'b0;
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mem_arvalid", mem_arvalid_o, 1'b0);
        chk("rst_mem_araddr", mem_araddr_o, 32'h0);
        chk("rst_mem_rready", mem_rready_o, 1'b0);
        chk("rst_rvalid", {ic_rvalid_o, dc_rvalid_o}, 2'b00);
        chk("rst_rdata", ic_rdata_o | dc_rdata_o, 256'h0);
        chk("rst_arready", {ic_arready_o, dc_arready_o}, 2'b00);

        // Single ICache refill
        tick;
        ic_arvalid_i  = 1'b1;
        ic_araddr_i   = 32'hDEBA_D01C;
        mem_arready_i = 1'b1;
        #1;
        chk("t1_ic_arready", ic_arready_o, 1'b1);
        chk("t1_dc_arready", dc_arready_o, 1'b0);
        tick;
        ic_arvalid_i = 1'b0;
        ic_araddr_i  = '0;
        #1;
        chk("t1_mem_arvalid", mem_arvalid_o, 1'b1);
        chk("t1_mem_araddr", mem_araddr_o, 32'hDEBA_D000);
        chk("t1_busy", busy_o, 1'b1);
        tick;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = D1;
        #1;
        chk("t1_mem_rready", mem_rready_o, 1'b1);
        chk("t1_dc_rvalid_data", dc_rvalid_o, 1'b0);
        tick;
        mem_rvalid_i = 1'b0;
        ic_rready_i  = 1'b1;
        #1;
        chk("t1_ic_rvalid", ic_rvalid_o, 1'b1);
        chk("t1_ic_rdata", ic_rdata_o, D1);
        chk("t1_dc_rvalid", dc_rvalid_o, 1'b0);
        chk("t1_dc_rdata", dc_rdata_o, 256'h0);
        chk("t1_resp_mem_rready", mem_rready_o, 1'b0);
        tick;
        ic_rready_i = 1'b0;
        #1;
        chk("t1_idle_busy", busy_o, 1'b0);
        chk("t1_idle_ic_rvalid", ic_rvalid_o, 1'b0);
        chk("t1_idle_ic_rdata", ic_rdata_o, 256'h0);

        // Simultaneous requests straight after reset: ICache first
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ic_arvalid_i  = 1'b1;
        ic_araddr_i   = 32'h2468_7570;
        dc_arvalid_i  = 1'b1;
        dc_araddr_i   = 32'h3348_7570;
        mem_arready_i = 1'b1;
        run_txn("t2_ic", 1'b0, 32'h2468_7560, D1);
        ic_arvalid_i = 1'b0;
        run_txn("t2_dc", 1'b1, 32'h3348_7560, D2);

        // Continuous simultaneous requests alternate
        ic_arvalid_i = 1'b1;
        ic_araddr_i  = 32'h1111_1123;
        dc_araddr_i  = 32'h2222_2245;
        run_txn("t3_0", 1'b0, 32'h1111_1120, D5);
        run_txn("t3_1", 1'b1, 32'h2222_2240, D6);
        run_txn("t3_2", 1'b0, 32'h1111_1120, D2);
        run_txn("t3_3", 1'b1, 32'h2222_2240, D1);

        // Memory address back-pressure, then owner back-pressure
        ic_arvalid_i  = 1'b0;
        dc_arvalid_i  = 1'b1;
        dc_araddr_i   = 32'h0BAD_F00F;
        mem_arready_i = 1'b0;
        #1;
        chk("t4_dc_arready", dc_arready_o, 1'b1);
        tick;
        dc_arvalid_i = 1'b0;
        ic_arvalid_i = 1'b1;
        ic_araddr_i  = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4_arvalid_%0d", i), mem_arvalid_o, 1'b1);
            chk($sformatf("t4_araddr_%0d", i), mem_araddr_o, 32'h0BAD_F000);
            chk($sformatf("t4_noready_%0d", i),
                {ic_arready_o, dc_arready_o}, 2'b00);
            tick;
        end
        mem_arready_i = 1'b1;
        tick;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = D5;
        tick;
        mem_rdata_i = D6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_rvalid_%0d", i), dc_rvalid_o, 1'b1);
            chk($sformatf("t5_rdata_%0d", i), dc_rdata_o, D5);
            chk($sformatf("t5_mem_rready_%0d", i), mem_rready_o, 1'b0);
            chk($sformatf("t5_busy_%0d", i), busy_o, 1'b1);
            tick;
        end
        mem_rvalid_i = 1'b0;
        dc_rready_i  = 1'b1;
        #1;
        chk("t5_hs_rvalid", dc_rvalid_o, 1'b1);
        tick;
        dc_rready_i = 1'b0;
        #1;
        chk("t5_pending_ic_arready", ic_arready_o, 1'b1);
        chk("t5_idle_busy", busy_o, 1'b0);

        // Reset while in DATA aborts the ICache transaction
        tick;
        ic_arvalid_i = 1'b0;
        #1;
        chk("t6_mem_araddr", mem_araddr_o, 32'h7777_7760);
        tick;
        #1;
        chk("t6_mem_rready", mem_rready_o, 1'b1);
        rst = 1'b1;
        tick;
        #1;
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_mem_arvalid", mem_arvalid_o, 1'b0);
        chk("t6_mem_rready_rst", mem_rready_o, 1'b0);
        chk("t6_mem_araddr_rst", mem_araddr_o, 32'h0);
        chk("t6_rvalid", {ic_rvalid_o, dc_rvalid_o}, 2'b00);
        chk("t6_rdata", ic_rdata_o | dc_rdata_o, 256'h0);
        rst          = 1'b0;
        dc_arvalid_i = 1'b1;
        dc_araddr_i  = 32'h4444_4444;
        run_txn("t6_dc", 1'b1, 32'h4444_4440, D6);
        dc_arvalid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/refill_read_arbiter.md
Name: refill_read_arbiter

Overview:
- Shares the single memory read channel (line refill port) between the ICache and DCache refill requesters.
- Each requester drives a valid/ready address channel and a valid/ready line-data channel.
- The arbiter grants one requester at a time, forwards the line-aligned address to memory, buffers the returned line and hands it back to the owner.
- Sits between both caches and the memory/AXI bridge.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, refill line width in bits; line offset bits OFF = log2(LINE_W/8) = 5

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_arvalid_i  in  1  ICache refill request
ic_araddr_i  in  ADDR_W  ICache miss address
ic_arready_o  out  1  ICache request accepted
ic_rvalid_o  out  1  ICache line data valid
ic_rdata_o  out  LINE_W  ICache line data
ic_rready_i  in  1  ICache ready for line
dc_arvalid_i  in  1  DCache refill request
dc_araddr_i  in  ADDR_W  DCache miss address
dc_arready_o  out  1  DCache request accepted
dc_rvalid_o  out  1  DCache line data valid
dc_rdata_o  out  LINE_W  DCache line data
dc_rready_i  in  1  DCache ready for line
mem_arvalid_o  out  1  address valid to memory
mem_araddr_o  out  ADDR_W  line-aligned address to memory
mem_arready_i  in  1  memory accepted address
mem_rvalid_i  in  1  memory line data valid
mem_rdata_i  in  LINE_W  memory line data
mem_rready_o  out  1  arbiter ready for memory data
busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: state = IDLE; owner = IC; last_grant = DC (first tie goes to ICache); line buffer = 0; addr reg = 0. All valid/ready outputs 0; mem_araddr_o = 0; rdata outputs = 0.
- Reset mid-transaction aborts it: return to IDLE with no rvalid. The memory side is assumed reset together.

State IDLE:
- Grant is combinational: ic_arready_o / dc_arready_o = 1 for the selected requester only, in this state only.
- Selection when only one arvalid is high: that requester.
- Selection when both are high: the one not equal to last_grant (round-robin).
- On grant:
  - addr_reg <= {araddr[ADDR_W-1:OFF], OFF'b0}
  - owner <= winner
  - last_grant <= winner
  - next state = ADDR
- With no request, stay in IDLE.

State ADDR:
- mem_arvalid_o = 1 and mem_araddr_o = addr_reg, both held stable until mem_arready_i.
- On mem_arready_i, go to DATA next cycle.
- If mem_arready_i is high in the first ADDR cycle, ADDR lasts exactly 1 cycle.

State DATA:
- mem_rready_o = 1.
- On mem_rvalid_i: line buffer <= mem_rdata_i; go to RESP.
- Wait indefinitely otherwise; there is no timeout.

State RESP:
- Only the owner's rvalid_o = 1; its rdata_o = line buffer. The non-owner's rvalid_o = 0 and its rdata_o = 0.
- On owner rready_i, go to IDLE next cycle; a same-cycle handshake completes in 1 cycle.
- mem_rready_o = 0 in this state, so further memory beats are back-pressured.

Rules:
- Requests are not accepted while busy_o = 1. A non-owner's arvalid stays pending and is granted in the next IDLE cycle.
- A requester must hold arvalid and araddr until its arready; the arbiter does not latch unaccepted requests.
- Minimum latency with zero memory wait:
  - grant at cycle 0
  - mem_arvalid_o at cycle 1
  - data captured at cycle 2
  - rvalid_o at cycle 3
  - IDLE at cycle 4
  - next grant at cycle 4
- Outputs mem_arvalid_o, mem_rready_o, rvalid_o and busy_o decode from registered state only; arready_o depends on state and arvalid.

Test Plan:
- ICache only, ic_araddr_i = 32'hDEBA_D01C, mem_arready_i = 1, rvalid 3 cycles after arvalid with rdata = 256'h12345678_..._78910234 -> mem_araddr_o = 32'hDEBA_D000; ic_rvalid_o with ic_rdata_o equal to that value; dc_rvalid_o never 1.
- Both request in the same cycle after reset (ic 32'h24687570, dc 32'h33487570) -> ICache granted first (mem_araddr_o = 32'h24687560). DCache granted in the IDLE cycle after the ICache RESP handshake (mem_araddr_o = 32'h33487560).
- Continuous simultaneous requests over 4 transactions -> grant order IC, DC, IC, DC.
- mem_arready_i held 0 for 5 cycles -> mem_arvalid_o and mem_araddr_o stable all 5 cycles; no arready_o to either cache during that time.
- Owner holds rready 0 for 4 cycles in RESP -> rvalid_o and rdata stable; mem_rready_o = 0; busy_o = 1.
- rst asserted during DATA -> next cycle all outputs at reset values; a new DCache request is then granted normally.
